// File: rtl/word_copy.sv
// word_copy: register-programmed engine that copies nwords 32-bit words from src to dst.
// Slave port programs the engine; master port issues one read then one write per word.
module word_copy (
   input  logic        clk,
   input  logic        rst_n,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   output logic [31:0] slave_readdata,
   input  logic        master_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   output logic        master_write,
   output logic [31:0] master_writedata,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid
);

   typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

   state_e      state_q, state_d;
   logic        ack_q, ack_d;
   logic [31:0] src_q, dst_q, nwords_q, idx_q, data_q, rdata_q;
   logic [31:0] reg_rdata;
   logic        slave_req, busy, wr_done, start, capture, wr_accept, last_word;

   assign slave_req         = slave_read | slave_write;
   assign busy              = (state_q != StIdle);
   assign slave_waitrequest = slave_req & ~ack_q;
   // Never acknowledged while a copy runs, so reads of offset 0 block until done.
   assign ack_d             = ~ack_q & slave_req & ~busy;
   assign wr_done           = ack_q & slave_write;
   assign start             = wr_done & (slave_address == 4'd0);
   assign capture           = master_readdatavalid &
                              ((state_q == StRdWait) |
                               ((state_q == StRdReq) & ~master_waitrequest));
   assign wr_accept         = (state_q == StWrReq) & ~master_waitrequest;
   assign last_word         = (idx_q + 32'd1) == nwords_q;
   assign slave_readdata    = rdata_q;

   always_comb begin
      reg_rdata = '0;
      case (slave_address)
         4'd1:    reg_rdata = src_q;
         4'd2:    reg_rdata = dst_q;
         4'd3:    reg_rdata = nwords_q;
         default: reg_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         ack_q    <= 1'b0;
         src_q    <= '0;
         dst_q    <= '0;
         nwords_q <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         rdata_q  <= '0;
      end else begin
         ack_q <= ack_d;
         if (ack_d & slave_read) begin
            rdata_q <= reg_rdata;
         end
         if (wr_done) begin
            case (slave_address)
               4'd1:    src_q    <= slave_writedata;
               4'd2:    dst_q    <= slave_writedata;
               4'd3:    nwords_q <= slave_writedata;
               default: ;
            endcase
         end
         if (start) begin
            idx_q <= '0;
         end else if (wr_accept) begin
            idx_q <= idx_q + 32'd1;
         end
         if (capture) begin
            data_q <= master_readdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start && (nwords_q != 32'd0)) state_d = StRdReq;
         end
         StRdReq: begin
            // Read data may already be valid in the cycle the read is accepted.
            if (!master_waitrequest) state_d = master_readdatavalid ? StWrReq : StRdWait;
         end
         StRdWait: begin
            if (master_readdatavalid) state_d = StWrReq;
         end
         StWrReq: begin
            if (!master_waitrequest) state_d = last_word ? StIdle : StRdReq;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      master_read      = 1'b0;
      master_write     = 1'b0;
      master_address   = '0;
      master_writedata = '0;
      unique case (state_q)
         StRdReq: begin
            master_read    = 1'b1;
            master_address = src_q + {idx_q[29:0], 2'b00};
         end
         StWrReq: begin
            master_write     = 1'b1;
            master_address   = dst_q + {idx_q[29:0], 2'b00};
            master_writedata = data_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_word_copy.sv
// Randomized bench for word_copy: a stalling memory model logs master traffic and
// each copy is compared against the expected read/write sequence.
module tb_word_copy;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        slave_waitrequest;
   logic [3:0]  slave_address;
   logic        slave_read, slave_write;
   logic [31:0] slave_writedata, slave_readdata;
   logic        master_waitrequest;
   logic [31:0] master_address;
   logic        master_read, master_write;
   logic [31:0] master_writedata, master_readdata;
   logic        master_readdatavalid;

   always #5 clk = ~clk;

   word_copy dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .slave_waitrequest    (slave_waitrequest),
      .slave_address        (slave_address),
      .slave_read           (slave_read),
      .slave_write          (slave_write),
      .slave_writedata      (slave_writedata),
      .slave_readdata       (slave_readdata),
      .master_waitrequest   (master_waitrequest),
      .master_address       (master_address),
      .master_read          (master_read),
      .master_write         (master_write),
      .master_writedata     (master_writedata),
      .master_readdata      (master_readdata),
      .master_readdatavalid (master_readdatavalid)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory model configuration
   int          stall_n   = 0;
   int          rd_delay  = 0;
   bit          use_const = 1'b0;
   logic [31:0] const_data = 32'hFEFE_FEFE;

   logic [31:0] rd_log[$];
   logic [31:0] wa_log[$];
   logic [31:0] wd_log[$];

   int          stall_cnt;
   bit          pend_active;
   int          pend_cnt;
   logic [31:0] pend_addr;
   bit          prev_hold;
   logic [31:0] prev_addr, prev_wdata;
   logic [1:0]  prev_rw;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      if (use_const) return const_data;
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory responder and bus monitor; decisions made on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         stall_cnt            = 0;
         pend_active          = 1'b0;
         prev_hold            = 1'b0;
         master_waitrequest   = 1'b0;
         master_readdatavalid = 1'b0;
         master_readdata      = 32'h0;
      end else begin
         if (prev_hold) begin
            check_eq("hold_addr", master_address, prev_addr);
            check_eq("hold_rw", {30'd0, master_read, master_write}, {30'd0, prev_rw});
            check_eq("hold_wdata", master_writedata, prev_wdata);
         end
         check_eq("rw_excl", {31'd0, master_read & master_write}, 32'd0);
         if (use_const) begin
            master_readdatavalid = 1'b1;
            master_readdata      = const_data;
         end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
         end
         if (pend_active) begin
            if (pend_cnt == 0) begin
               master_readdatavalid = 1'b1;
               master_readdata      = mem_word(pend_addr);
               pend_active          = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (master_read || master_write) begin
            if (stall_cnt < stall_n) begin
               master_waitrequest = 1'b1;
               stall_cnt++;
            end else begin
               master_waitrequest = 1'b0;
               stall_cnt          = 0;
               if (master_read) begin
                  rd_log.push_back(master_address);
                  if (rd_delay == 0) begin
                     master_readdatavalid = 1'b1;
                     master_readdata      = mem_word(master_address);
                  end else begin
                     pend_active = 1'b1;
                     pend_cnt    = rd_delay - 1;
                     pend_addr   = master_address;
                  end
               end else begin
                  wa_log.push_back(master_address);
                  wd_log.push_back(master_writedata);
               end
            end
         end else begin
            master_waitrequest = 1'($urandom_range(0, 1));
         end
         prev_hold  = (master_read || master_write) && master_waitrequest;
         prev_addr  = master_address;
         prev_wdata = master_writedata;
         prev_rw    = {master_read, master_write};
      end
   end

   task automatic slave_access(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                               input int bound, output int waits, output logic [31:0] rdata);
      @(negedge clk);
      slave_address   = addr;
      slave_writedata = data;
      slave_write     = wr;
      slave_read      = ~wr;
      #1;
      waits = 0;
      while (slave_waitrequest && waits < bound) begin
         @(negedge clk);
         #1;
         waits++;
      end
      check_eq("slave_bound", {31'd0, slave_waitrequest}, 32'd0);
      @(posedge clk);
      #1;
      slave_read  = 1'b0;
      slave_write = 1'b0;
      rdata       = slave_readdata;
   endtask

   task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
      int          w;
      logic [31:0] r;
      slave_access(1'b1, addr, data, 50, w, r);
      check_eq("wr_waits", w, 32'd1);
   endtask

   task automatic rd_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      int          w;
      logic [31:0] r;
      slave_access(1'b0, addr, 32'h0, 50, w, r);
      check_eq("rd_waits", w, 32'd1);
      check_eq(tag, r, exp);
   endtask

   function automatic void clear_logs();
      rd_log.delete();
      wa_log.delete();
      wd_log.delete();
   endfunction

   // Program, start, block on offset 0, then compare traffic with the expected sequence.
   task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      int          w;
      logic [31:0] r;
      wr_reg(4'd1, src);
      wr_reg(4'd2, dst);
      wr_reg(4'd3, n);
      clear_logs();
      wr_reg(4'd0, 32'hDEAD_BEEF);
      repeat (10) @(negedge clk);
      slave_access(1'b0, 4'd0, 32'h0, 20000, w, r);
      check_eq("done_rdata", r, 32'h0);
      check_eq("done_nwr", wa_log.size(), n);
      check_eq("done_nrd", rd_log.size(), n);
      if (n > 8) check_eq("done_blocked", {31'd0, w > 8}, 32'd1);
      for (int k = 0; k < n && k < rd_log.size() && k < wa_log.size(); k++) begin
         check_eq("rd_addr", rd_log[k], src + 32'(k) * 32'd4);
         check_eq("wr_addr", wa_log[k], dst + 32'(k) * 32'd4);
         check_eq("wr_data", wd_log[k], mem_word(src + 32'(k) * 32'd4));
      end
   endtask

   initial begin
      int          w;
      logic [31:0] r;
      logic [31:0] s, d;
      rst_n           = 1'b1;
      slave_address   = 4'd0;
      slave_read      = 1'b0;
      slave_write     = 1'b0;
      slave_writedata = 32'h0;

      // Reset state, and waitrequest following the request while ack is held low
      repeat (3) @(negedge clk);
      check_eq("rst_waitreq_idle", {31'd0, slave_waitrequest}, 32'd0);
      check_eq("rst_readdata", slave_readdata, 32'h0);
      check_eq("rst_mread", {31'd0, master_read}, 32'd0);
      check_eq("rst_mwrite", {31'd0, master_write}, 32'd0);
      check_eq("rst_maddr", master_address, 32'h0);
      check_eq("rst_mwdata", master_writedata, 32'h0);
      slave_read = 1'b1;
      #1 check_eq("rst_waitreq_req", {31'd0, slave_waitrequest}, 32'd1);
      repeat (2) @(negedge clk);
      check_eq("rst_waitreq_hold", {31'd0, slave_waitrequest}, 32'd1);
      slave_read = 1'b0;
      rst_n      = 1'b0;

      // Register access and handshake
      wr_reg(4'd1, 32'hAAAA_1110);
      wr_reg(4'd2, 32'hBBBB_2220);
      wr_reg(4'd3, 32'h0000_0100);
      rd_reg("rd_src", 4'd1, 32'hAAAA_1110);
      rd_reg("rd_dst", 4'd2, 32'hBBBB_2220);
      rd_reg("rd_nwords", 4'd3, 32'h0000_0100);
      rd_reg("rd_ctrl", 4'd0, 32'h0);
      wr_reg(4'd9, 32'h1234_5678);
      rd_reg("rd_unmapped", 4'd9, 32'h0);
      rd_reg("rd_src_after", 4'd1, 32'hAAAA_1110);
      @(negedge clk);
      check_eq("rdata_held", slave_readdata, 32'hAAAA_1110);

      // Full 256-word copy against a zero-latency memory
      use_const = 1'b1;
      stall_n   = 0;
      rd_delay  = 0;
      run_copy(32'hAAAA_1110, 32'hBBBB_2220, 256);

      // Stalling memory with delayed read data
      use_const = 1'b0;
      stall_n   = 3;
      rd_delay  = 2;
      run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 8);

      // Random timing, including wrap past 2^32
      for (int t = 0; t < 6; t++) begin
         stall_n  = $urandom_range(0, 3);
         rd_delay = $urandom_range(0, 3);
         s = (t % 2 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         d = (t % 3 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         run_copy(s, d, $urandom_range(1, 12));
      end

      // nwords == 0: no master traffic, offset-0 read completes after one wait
      wr_reg(4'd3, 32'h0);
      clear_logs();
      wr_reg(4'd0, 32'h0);
      slave_access(1'b0, 4'd0, 32'h0, 50, w, r);
      check_eq("zero_waits", w, 32'd1);
      check_eq("zero_rdata", r, 32'h0);
      repeat (3) @(negedge clk);
      check_eq("zero_nrd", rd_log.size(), 32'd0);
      check_eq("zero_nwr", wa_log.size(), 32'd0);

      // Reset in the middle of a copy
      stall_n  = 1;
      rd_delay = 1;
      wr_reg(4'd1, 32'h0000_1000);
      wr_reg(4'd2, 32'h0000_8000);
      wr_reg(4'd3, 32'd50);
      wr_reg(4'd0, 32'h0);
      repeat (20) @(negedge clk);
      check_eq("mid_busy", {31'd0, master_read | master_write}, 32'd1);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort_mread", {31'd0, master_read}, 32'd0);
      check_eq("abort_mwrite", {31'd0, master_write}, 32'd0);
      check_eq("abort_maddr", master_address, 32'h0);
      check_eq("abort_rdata", slave_readdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      rd_reg("abort_src", 4'd1, 32'h0);
      rd_reg("abort_dst", 4'd2, 32'h0);
      rd_reg("abort_nwords", 4'd3, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/word_copy.md
WORD_COPY -- requirements
Module: word_copy

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-high reset (asserted = 1, sampled on rising clk).
REQ-003 SHALL have port: slave_waitrequest  output  1  stall for CPU-side access.
REQ-004 SHALL have port: slave_address  input  4  word offset of register.
REQ-005 SHALL have ports: slave_read input 1, slave_write input 1, slave_writedata input 32, slave_readdata output 32.
REQ-006 SHALL have port: master_waitrequest  input  1  memory stall.
REQ-007 SHALL have ports: master_address output 32 byte address, master_read output 1, master_write output 1, master_writedata output 32.
REQ-008 SHALL have ports: master_readdata input 32, master_readdatavalid input 1.
REQ-009 Registers: offset 0 = start/status, 1 = src (byte addr), 2 = dst (byte addr), 3 = nwords; offsets 4-15 read 0, writes ignored.

Function
REQ-010 Slave handshake: slave_waitrequest = (slave_read | slave_write) & ~ack, combinational; ack is a flop set on the edge after a request is first seen and cleared on the next edge; each access therefore stalls exactly one cycle when idle.
REQ-011 A slave write completes on the edge where waitrequest is low; writes to offsets 1-3 load the full 32-bit value.
REQ-012 slave_readdata SHALL be registered, loaded on the edge that sets ack, and held unchanged until the next read is loaded.
REQ-013 Offset 0 read returns 0; offset 1-3 reads return the stored value.
REQ-014 Write to offset 0 (data ignored) while idle SHALL start a copy on its completing edge.
REQ-015 While busy, any slave access SHALL hold slave_waitrequest high (ack not set) until the copy is done; it then completes per REQ-010. A read of offset 0 is thereby the "wait for done" primitive.
REQ-016 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE-check; IDLE->RD_REQ on start if nwords != 0, else stay IDLE.
REQ-017 RD_REQ: master_read=1, master_address = src + 4*i; hold until master_waitrequest=0, then RD_WAIT.
REQ-018 RD_WAIT: capture master_readdata on first cycle with master_readdatavalid=1 (valid may coincide with acceptance cycle); go to WR_REQ.
REQ-019 WR_REQ: master_write=1, master_address = dst + 4*i, master_writedata = captured word; hold until master_waitrequest=0; then i <= i+1; if i+1 == nwords -> IDLE else RD_REQ.
REQ-020 Only one outstanding master transaction; master_read and master_write never both high.
REQ-021 Address arithmetic is 32-bit modulo 2^32 (wraps); i counter 32 bits; src/dst/nwords sampled at start are used for the whole copy (writes during busy are stalled anyway).
REQ-022 Idle: master_read=0, master_write=0; master_address/writedata don't-care but SHALL be 0 after reset.

Reset
REQ-023 rst_n=1 on a rising edge SHALL force IDLE, ack=0, src=dst=nwords=0, i=0, slave_readdata=0, master_read=master_write=0, master_address=master_writedata=0, aborting any copy in progress.
REQ-024 slave_waitrequest during reset follows REQ-010 with ack=0.

Verification
REQ-025 Write 0xAAAA1110 to offset 1, 0xBBBB2220 to 2, 0x100 to 3 -> each write sees waitrequest high one cycle then low; reads of offsets 1,2,3 return those values after handshake.
REQ-026 Start copy (write offset 0) with nwords=0x100, memory waitrequest=0, readdatavalid=1, readdata=0xFEFEFEFE -> 256 reads at 0xAAAA1110+4i and 256 writes of 0xFEFEFEFE at 0xBBBB2220+4i, in order.
REQ-027 Read offset 0 ten cycles after start -> waitrequest stays high until the 256th write is accepted, then drops; readdata = 0.
REQ-028 Memory with master_waitrequest high 3 cycles per access and readdatavalid delayed 2 cycles -> addresses/data held stable during stall; copy still correct.
REQ-029 nwords=0 then start -> no master transactions; offset-0 read completes after one wait cycle.
REQ-030 Assert rst_n mid-copy -> master_read/write drop next edge, registers read back 0.
